sram_req_ctrl: RTL and testbench
================================

Name: sram_req_ctrl

Overview:
- Request/response front end that drives the single-port word SRAM (ADDRESS/CS/WE/WDATA/RDATA) on behalf of a bus master.
- Accepts byte-addressed byte/half/word reads and writes over valid/ready.
- Checks range and alignment, generates byte-lane strobes and replicated write data, and aligns and zero-extends read data.
- Zero-fills the whole SRAM after reset, because the SRAM's own reset clears memory only while CS is high.

Parameters:
- ADDRWIDTH, 10, SRAM word-address width; depth = 2^ADDRWIDTH words of 32 bits.
- MEMBASE, 32'h0000_0000, byte address of SRAM word 0.
- MEMTOP, 32'h0000_0FFF, last valid byte address; must equal MEMBASE + 4*2^ADDRWIDTH - 1.
- INIT_CLEAR, 1, 1 = zero-fill the SRAM after reset; 0 = go straight to IDLE.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid && req_ready at posedge
- req_write  input  1  1 = write, 0 = read
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_addr  input  32  byte address
- req_wdata  input  32  write data, right-justified
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at posedge
- rsp_rdata  output  32  read data, right-justified and zero-extended; 0 for writes and errors
- rsp_err  output  1  range, alignment or size error
- init_done  output  1  high once the clear sweep has finished (held high thereafter)
- ADDRESS  output  ADDRWIDTH  SRAM word address
- CS  output  1  SRAM chip select
- WE  output  4  SRAM byte write enables
- WDATA  output  32  SRAM write data
- RDATA  input  32  SRAM read data, combinational from ADDRESS when CS && WE==0

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, ADDRESS=0, CS=0, WE=0, WDATA=0.
- Reset state is CLEAR if INIT_CLEAR=1, else IDLE with init_done=1.
- SRAM outputs are decoded only from the state and capture registers; there is no combinational path from req_* to the SRAM ports.
- FSM states: CLEAR, IDLE, ACCESS, RESP.
- CLEAR:
  - Drive CS=1, WE=4'hF, WDATA=0, ADDRESS=clr_cnt; one word per cycle.
  - clr_cnt counts 0 to 2^ADDRWIDTH-1.
  - After the last word, next state is IDLE and init_done=1 (sweep = 2^ADDRWIDTH cycles).
  - req_ready=0 throughout.
- IDLE: req_ready=1. On accept, capture write, size, addr and wdata, then evaluate errors:
  - size==3
  - size==1 && addr[0]
  - size==2 && addr[1:0]!=0
  - addr < MEMBASE or addr > MEMTOP
- On error: go to RESP with rsp_err=1, rsp_rdata=0; the SRAM is not touched (CS stays 0). Otherwise go to ACCESS.
- ACCESS (exactly one cycle): CS=1, ADDRESS=(addr-MEMBASE)[ADDRWIDTH+1:2].
- Write lanes:
  - size0: WE = 1<<addr[1:0], WDATA = {4{wdata[7:0]}}.
  - size1: WE = addr[1] ? 4'b1100 : 4'b0011, WDATA = {2{wdata[15:0]}}.
  - size2: WE = 4'hF, WDATA = wdata.
- Reads: WE=0, WDATA=0. RDATA is captured at the posedge ending ACCESS:
  - byte: (RDATA >> 8*addr[1:0]) & 8'hFF
  - half: (RDATA >> 16*addr[1]) & 16'hFFFF
  - word: RDATA
- Writes: rsp_rdata=0. Next state is RESP, rsp_err=0.
- RESP: rsp_valid=1; rsp_rdata and rsp_err stay stable until consumed.
  - req_ready = rsp_ready, so a new request can be accepted in the same cycle the response is consumed (back-to-back issue, 2 cycles/op).
  - If rsp_ready=1 and req_valid=0, go to IDLE. If rsp_ready=0, stay in RESP.
- Outside CLEAR/ACCESS: CS=0, WE=0, ADDRESS=0, WDATA=0.
- Asynchronous reset in any state:
  - Abandon the in-flight request and drop rsp_valid immediately; no partial write may follow.
  - The clear sweep restarts from word 0.
- A write followed by a read of the same word returns the new data, because the write commits at the ACCESS posedge before the next ACCESS.
- Address arithmetic is unsigned 32-bit. MEMTOP is inclusive; MEMBASE-1 and MEMTOP+1 both error.

Test Plan (ADDRWIDTH=4, MEMBASE=32'h100, MEMTOP=32'h13F, INIT_CLEAR=1):
- Reset release -> CS=1, WE=F, WDATA=0 for exactly 16 cycles with ADDRESS 0..15, then init_done=1 and req_ready=1; pre-loaded SRAM contents read back as 0.
- Word write 0x104 = 32'hDEADBEEF, then word read 0x104 -> ACCESS shows ADDRESS=1, WE=F; read returns rsp_rdata=32'hDEADBEEF, rsp_err=0, one response per 2 cycles with rsp_ready held 1.
- Byte write 0x106 = 8'h5A, then half write 0x104 = 16'h1234, then word read 0x104 -> WE=4'b0100 then 4'b0011; rsp_rdata=32'hDE5A1234. Byte read 0x107 -> 32'h000000DE.
- Errors: half read 0x105, word write 0x102, size=3, read 0x0FF, write 0x140 -> each gives rsp_err=1, rsp_rdata=0, with CS never asserted.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable, req_ready=0; next request accepted in the cycle rsp_ready rises.
- Assert rstn low during RESP of a pending write response and during CLEAR at word 7 -> rsp_valid=0 at once, no CS pulse during reset, sweep restarts at ADDRESS=0.

Source files
------------

// File: rtl/sram_req_ctrl.sv
// Valid/ready request front end for a single-port 32-bit word SRAM: range/alignment
// checking, byte-lane strobes, read alignment, and a zero-fill sweep after reset.
`timescale 1ns/1ps
module sram_req_ctrl #(
    parameter int          ADDRWIDTH  = 10,
    parameter logic [31:0] MEMBASE    = 32'h0000_0000,
    parameter logic [31:0] MEMTOP     = 32'h0000_0FFF,
    parameter int          INIT_CLEAR = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 init_done,
    output logic [ADDRWIDTH-1:0] ADDRESS,
    output logic                 CS,
    output logic [3:0]           WE,
    output logic [31:0]          WDATA,
    input  logic [31:0]          RDATA
);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [31:0]          SPAN     = MEMTOP - MEMBASE;
    localparam logic [ADDRWIDTH-1:0] CLR_LAST = '1;

    state_t                 state, state_nxt;
    logic                   clr_armed;
    logic [ADDRWIDTH-1:0]   clr_cnt;
    logic                   cap_write;
    logic [1:0]             cap_size;
    logic [1:0]             cap_lane;
    logic [ADDRWIDTH-1:0]   cap_word;
    logic [31:0]            cap_wdata;
    logic [32:0]            req_off;
    logic                   req_err;
    logic                   accept;
    logic [31:0]            rd_aligned;

    // 33-bit subtraction: bit 32 is the borrow, i.e. the address lies below MEMBASE.
    assign req_off = {1'b0, req_addr} - {1'b0, MEMBASE};
    assign req_err = (req_size == 2'd3)
                  || (req_size == 2'd1 && req_addr[0])
                  || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                  || req_off[32]
                  || (req_off[31:0] > SPAN);

    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_RESP);

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            S_CLEAR:  if (clr_armed && clr_cnt == CLR_LAST) state_nxt = S_IDLE;
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_err ? S_RESP : S_ACCESS;
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP: begin
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    if (req_valid) state_nxt = req_err ? S_RESP : S_ACCESS;
                    else           state_nxt = S_IDLE;
                end
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // SRAM pins come only from state and capture registers; the sweep is held off
    // until the first clock after reset so CS stays low while rstn is asserted.
    always_comb begin
        CS      = 1'b0;
        WE      = 4'h0;
        ADDRESS = '0;
        WDATA   = 32'h0;
        case (state)
            S_CLEAR: begin
                if (clr_armed) begin
                    CS      = 1'b1;
                    WE      = 4'hF;
                    ADDRESS = clr_cnt;
                end
            end
            S_ACCESS: begin
                CS      = 1'b1;
                ADDRESS = cap_word;
                if (cap_write) begin
                    case (cap_size)
                        2'd0: begin
                            WE    = 4'b0001 << cap_lane;
                            WDATA = {4{cap_wdata[7:0]}};
                        end
                        2'd1: begin
                            WE    = cap_lane[1] ? 4'b1100 : 4'b0011;
                            WDATA = {2{cap_wdata[15:0]}};
                        end
                        2'd2: begin
                            WE    = 4'hF;
                            WDATA = cap_wdata;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_aligned = RDATA;
        case (cap_size)
            2'd0:    rd_aligned = {24'h0, RDATA[{cap_lane, 3'b000} +: 8]};
            2'd1:    rd_aligned = {16'h0, (cap_lane[1] ? RDATA[31:16] : RDATA[15:0])};
            default: rd_aligned = RDATA;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
            clr_armed <= 1'b0;
            clr_cnt   <= '0;
            init_done <= (INIT_CLEAR == 0);
            cap_write <= 1'b0;
            cap_size  <= 2'd0;
            cap_lane  <= 2'd0;
            cap_word  <= '0;
            cap_wdata <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_armed <= 1'b1;
            if (state == S_CLEAR && clr_armed) begin
                clr_cnt <= clr_cnt + ADDRWIDTH'(1);
                if (clr_cnt == CLR_LAST) init_done <= 1'b1;
            end
            if (accept) begin
                cap_write <= req_write;
                cap_size  <= req_size;
                cap_lane  <= req_addr[1:0];
                cap_word  <= req_off[ADDRWIDTH+1:2];
                cap_wdata <= req_wdata;
                rsp_rdata <= 32'h0;
                rsp_err   <= req_err;
            end
            if (state == S_ACCESS) begin
                rsp_rdata <= cap_write ? 32'h0 : rd_aligned;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl: directed vector table, multi-cycle corner
// sequences, and random traffic against a byte-array reference model.
`timescale 1ns/1ps
module tb_sram_req_ctrl;

    localparam int          AW   = 4;
    localparam logic [31:0] BASE = 32'h100;
    localparam logic [31:0] TOP  = 32'h13F;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid, req_ready, req_write;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err, init_done;
    logic [AW-1:0] ADDRESS;
    logic          CS;
    logic [3:0]    WE;
    logic [31:0]   WDATA, RDATA;

    always #5 clk = ~clk;

    sram_req_ctrl #(.ADDRWIDTH(AW), .MEMBASE(BASE), .MEMTOP(TOP), .INIT_CLEAR(1)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .init_done(init_done),
        .ADDRESS(ADDRESS), .CS(CS), .WE(WE), .WDATA(WDATA), .RDATA(RDATA)
    );

    // SRAM environment model: byte-enabled write on posedge, combinational read.
    logic [31:0] sram [16];
    logic        preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) sram[i] <= 32'hA5A5_0000 | 32'(i);
        end else if (CS) begin
            for (int b = 0; b < 4; b++)
                if (WE[b]) sram[ADDRESS][8*b +: 8] <= WDATA[8*b +: 8];
        end
    end
    assign RDATA = (CS && WE == 4'h0) ? sram[ADDRESS] : 32'hBAD0_BAD0;

    int cs_rst_bad = 0;
    always @(negedge clk) if (!rstn && CS) cs_rst_bad++;

    int n_checks = 0;
    int n_pass   = 0;
    int stable_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        $display("FAIL %s: got no DUT event expected one within the cycle bound", name);
    endtask

    // Reference model: byte-addressed memory image relative to BASE.
    logic [7:0] ref_mem [64];

    task automatic model_clear();
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    endtask

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        int unsigned nbytes = 1 << sz;
        if (sz == 2'd3) return 1'b1;
        if (a < BASE || a > TOP) return 1'b1;
        return (a % nbytes) != 0;
    endfunction

    task automatic model_access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int idx;
        rd = 32'h0;
        er = model_err(sz, a);
        if (!er) begin
            idx = int'(a - BASE);
            for (int b = 0; b < (1 << sz); b++) begin
                if (w) ref_mem[idx + b] = wd[8*b +: 8];
                else   rd[8*b +: 8] = ref_mem[idx + b];
            end
        end
    endtask

    // One request from IDLE; returns the response and what the SRAM pins showed.
    task automatic transact(input logic w, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input int stall,
                            output logic [31:0] rd, output logic er, output int cs_n,
                            output logic [3:0] we_seen, output logic [AW-1:0] adr_seen);
        int k;
        rd = 32'h0; er = 1'b0; cs_n = 0; we_seen = 4'h0; adr_seen = '0;
        req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
        rsp_ready = (stall == 0);
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        if (!req_ready) begin
            fail_bound("accept");
            req_valid = 1'b0; rsp_ready = 1'b1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            if (CS) begin cs_n++; we_seen = WE; adr_seen = ADDRESS; end
            @(negedge clk); k++;
        end
        if (!rsp_valid) begin
            fail_bound("response");
            rsp_ready = 1'b1;
            return;
        end
        rd = rsp_rdata; er = rsp_err;
        repeat (stall) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || req_ready) stable_bad++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks reset outputs, releases reset and follows the clear sweep; abort_at >= 0
    // reasserts reset while the sweep is on that word.
    task automatic run_sweep(input int abort_at);
        int k, n, bad;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 32'({req_ready, rsp_valid, rsp_err, init_done, CS, WE, ADDRESS}), 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_wdata", WDATA, 32'h0);
        rstn = 1'b1;
        k = 0;
        while (!CS && k < 5) begin @(negedge clk); k++; end
        if (!CS) begin fail_bound("sweep_start"); return; end
        check("sweep_start_addr", 32'(ADDRESS), 32'h0);
        n = 0; bad = 0;
        while (CS && n < 40) begin
            if (WE != 4'hF || WDATA != 32'h0 || ADDRESS != AW'(n) || init_done || req_ready) bad++;
            if (abort_at == n) begin
                #2 rstn = 1'b0;
                #1;
                check("abort_cs_drop", 32'({CS, WE}), 32'h0);
                check("abort_sweep_bad", 32'(bad), 32'h0);
                return;
            end
            n++;
            @(negedge clk);
        end
        check("sweep_len", 32'(n), 32'd16);
        check("sweep_bad", 32'(bad), 32'h0);
        check("sweep_done", 32'({init_done, req_ready}), 32'h3);
    endtask

    typedef struct {
        logic          w;
        logic [1:0]    sz;
        logic [31:0]   a;
        logic [31:0]   wd;
        logic [31:0]   exp_rd;
        logic          exp_err;
        logic [3:0]    exp_we;
        logic [AW-1:0] exp_adr;
    } vec_t;

    vec_t vecs [20];

    initial begin
        logic [31:0]   rd, exp_rd, got;
        logic          er, exp_er, w;
        logic [1:0]    sz;
        logic [31:0]   a, wd;
        logic [3:0]    wes;
        logic [AW-1:0] ads;
        int            csn, nrsp, ncs, bad, k, r, stall;

        vecs[0]  = '{1'b1, 2'd2, 32'h104, 32'hDEADBEEF, 32'h0,        1'b0, 4'hF, 4'h1};
        vecs[1]  = '{1'b0, 2'd2, 32'h104, 32'h0,        32'hDEADBEEF, 1'b0, 4'h0, 4'h1};
        vecs[2]  = '{1'b1, 2'd0, 32'h106, 32'h1122335A, 32'h0,        1'b0, 4'h4, 4'h1};
        vecs[3]  = '{1'b1, 2'd1, 32'h104, 32'hABCD1234, 32'h0,        1'b0, 4'h3, 4'h1};
        vecs[4]  = '{1'b0, 2'd2, 32'h104, 32'h0,        32'hDE5A1234, 1'b0, 4'h0, 4'h1};
        vecs[5]  = '{1'b0, 2'd0, 32'h107, 32'h0,        32'h000000DE, 1'b0, 4'h0, 4'h1};
        vecs[6]  = '{1'b0, 2'd1, 32'h106, 32'h0,        32'h0000DE5A, 1'b0, 4'h0, 4'h1};
        vecs[7]  = '{1'b0, 2'd0, 32'h105, 32'h0,        32'h00000012, 1'b0, 4'h0, 4'h1};
        vecs[8]  = '{1'b0, 2'd1, 32'h105, 32'h0,        32'h0,        1'b1, 4'h0, 4'h0};
        vecs[9]  = '{1'b1, 2'd2, 32'h102, 32'hFFFFFFFF, 32'h0,        1'b1, 4'h0, 4'h0};
        vecs[10] = '{1'b0, 2'd3, 32'h104, 32'h0,        32'h0,        1'b1, 4'h0, 4'h0};
        vecs[11] = '{1'b0, 2'd0, 32'h0FF, 32'h0,        32'h0,        1'b1, 4'h0, 4'h0};
        vecs[12] = '{1'b1, 2'd0, 32'h140, 32'h000000FF, 32'h0,        1'b1, 4'h0, 4'h0};
        vecs[13] = '{1'b0, 2'd2, 32'h13C, 32'h0,        32'h0,        1'b0, 4'h0, 4'hF};
        vecs[14] = '{1'b1, 2'd0, 32'h13F, 32'h00000077, 32'h0,        1'b0, 4'h8, 4'hF};
        vecs[15] = '{1'b0, 2'd2, 32'h13C, 32'h0,        32'h77000000, 1'b0, 4'h0, 4'hF};
        vecs[16] = '{1'b0, 2'd2, 32'h100, 32'h0,        32'h0,        1'b0, 4'h0, 4'h0};
        vecs[17] = '{1'b1, 2'd1, 32'h13E, 32'h0000BEEF, 32'h0,        1'b0, 4'hC, 4'hF};
        vecs[18] = '{1'b0, 2'd2, 32'h13C, 32'h0,        32'hBEEF0000, 1'b0, 4'h0, 4'hF};
        vecs[19] = '{1'b0, 2'd1, 32'h13E, 32'h0,        32'h0000BEEF, 1'b0, 4'h0, 4'hF};

        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        run_sweep(-1);
        model_clear();

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            model_access(vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].wd, exp_rd, exp_er);
            transact(vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].wd, 0, rd, er, csn, wes, ads);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_cs", i), 32'(csn), vecs[i].exp_err ? 32'd0 : 32'd1);
            if (!vecs[i].exp_err) begin
                check($sformatf("vec%0d_we", i), 32'(wes), 32'(vecs[i].exp_we));
                check($sformatf("vec%0d_addr", i), 32'(ads), 32'(vecs[i].exp_adr));
            end
        end

        // Backpressure: response held 5 cycles, waiting request taken when rsp_ready rises
        model_access(1'b0, 2'd2, 32'h104, 32'h0, exp_rd, exp_er);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h104; rsp_ready = 1'b0;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        if (!rsp_valid) fail_bound("bp_response");
        check("bp_rdata", rsp_rdata, exp_rd);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h110; req_wdata = 32'h0BADF00D;
        bad = 0;
        repeat (5) begin
            if (!rsp_valid || rsp_rdata !== exp_rd || rsp_err || req_ready) bad++;
            @(negedge clk);
        end
        check("bp_hold_bad", 32'(bad), 32'h0);
        rsp_ready = 1'b1;
        #1 check("bp_req_ready_follow", 32'(req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("bp_accept_same_cycle", 32'({rsp_valid, CS, WE}), 32'h1F);
        req_valid = 1'b0;
        model_access(1'b1, 2'd2, 32'h110, 32'h0BADF00D, exp_rd, exp_er);
        k = 0;
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);

        // Back-to-back reads with rsp_ready held: one response every 2 cycles
        model_access(1'b0, 2'd2, 32'h110, 32'h0, exp_rd, exp_er);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h110;
        nrsp = 0; ncs = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) begin nrsp++; if (rsp_rdata !== exp_rd) bad++; end
            if (CS) ncs++;
        end
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_rsp_count", 32'(nrsp), 32'd4);
        check("b2b_cs_count", 32'(ncs), 32'd4);
        check("b2b_rdata_bad", 32'(bad), 32'h0);

        // Random traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = BASE - 32'd8 + 32'($urandom_range(0, 'h50));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~32'((1 << sz) - 1);
            wd = $urandom;
            stall = int'($urandom_range(0, 2));
            model_access(w, sz, a, wd, exp_rd, exp_er);
            transact(w, sz, a, wd, stall, rd, er, csn, wes, ads);
            check($sformatf("rnd%0d_rdata", i), rd, exp_rd);
            check($sformatf("rnd%0d_err", i), 32'(er), 32'(exp_er));
            check($sformatf("rnd%0d_cs", i), 32'(csn), exp_er ? 32'd0 : 32'd1);
        end

        for (int i = 0; i < 16; i++) begin
            got = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
            check($sformatf("mem_word%0d", i), sram[i], got);
        end
        check("stable_bad", 32'(stable_bad), 32'h0);

        // Reset while a write response is pending
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h108;
        req_wdata = 32'h000000AA; rsp_ready = 1'b0;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        check("resp_pending", 32'(rsp_valid), 32'h1);
        #2 rstn = 1'b0;
        #1;
        check("rst_rsp_drop", 32'({rsp_valid, CS}), 32'h0);
        rsp_ready = 1'b1;
        model_clear();
        run_sweep(-1);

        // Reset during the sweep at word 7, then a full restart
        req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        run_sweep(7);
        run_sweep(-1);

        model_access(1'b0, 2'd2, 32'h108, 32'h0, exp_rd, exp_er);
        transact(1'b0, 2'd2, 32'h108, 32'h0, 0, rd, er, csn, wes, ads);
        check("post_rst_rd108", rd, exp_rd);
        model_access(1'b0, 2'd2, 32'h110, 32'h0, exp_rd, exp_er);
        transact(1'b0, 2'd2, 32'h110, 32'h0, 0, rd, er, csn, wes, ads);
        check("post_rst_rd110", rd, exp_rd);
        check("cs_in_reset", 32'(cs_rst_bad), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected it within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
